mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequential arbiter and sequencer that shares one single-port, fixed-latency word memory between the processor's instruction-fetch requester and its data (load/store) requester. It sits between `processor` and the unified memory and generates the `DataDone` completion handshake the memory stages stall on. It also generates the equivalent `InstrDone` for the fetch side. Data accesses have priority, and a bounded starvation guard keeps fetch progressing.

## Interface
Parameters:
- `WORD_SIZE`, 16, data width in bits.
- `ADDR_BITS`, 16, address width in bits.
- `MEM_LATENCY`, 1, cycles from the memory strobe to a valid `MemRData`; legal range 1..15.
- `STARVE_LIMIT`, 4, maximum consecutive data grants allowed while fetch is pending; legal range 1..15.

Ports:
- `Clock`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `DataAddr`  in  ADDR_BITS  data request address.
- `DataOut`  in  WORD_SIZE  store data.
- `ReadData`  in  1  load request; held by the requester until `DataDone`.
- `WriteData`  in  1  store request; held by the requester until `DataDone`.
- `DataIn`  out  WORD_SIZE  load result; valid while `DataDone`=1.
- `DataDone`  out  1  one-cycle completion pulse for the data requester.
- `InstrReq`  in  1  fetch request; held by the requester until `InstrDone`.
- `InstrAddr`  in  ADDR_BITS  fetch address.
- `InstrIn`  out  WORD_SIZE  fetched word; valid while `InstrDone`=1.
- `InstrDone`  out  1  one-cycle completion pulse for the fetch requester.
- `MemAddr`  out  ADDR_BITS  memory address.
- `MemWData`  out  WORD_SIZE  memory write data.
- `MemRead`  out  1  one-cycle memory read strobe.
- `MemWrite`  out  1  one-cycle memory write strobe.
- `MemRData`  in  WORD_SIZE  memory read data; valid exactly `MEM_LATENCY` cycles after `MemRead`.

## Operation
FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.

- **IDLE**
  - Requests are sampled only in this state.
  - A data request is `ReadData|WriteData`.
  - If both `ReadData` and `WriteData` are high, the access is a write and the read is ignored.
  - Grant rule:
    - Only one side requesting: that side wins.
    - Both requesting: data wins, unless `starve_cnt`==`STARVE_LIMIT`, in which case instr wins.
  - On a grant, register the address, write data, the write flag and the granting side, then go to ISSUE.
  - With no request, stay in IDLE.
- **starve_cnt** (4-bit counter)
  - Increments on a data grant made while `InstrReq`=1.
  - Clears on an instr grant, or on a data grant made while `InstrReq`=0.
  - Saturates at `STARVE_LIMIT`.
- **ISSUE**
  - Drives `MemAddr` from the registered address and pulses `MemRead` or `MemWrite` for exactly one cycle.
  - `MemWData` is driven from the registered store data during a write.
  - Write: go to DONE.
  - Read: load the wait counter with `MEM_LATENCY`-1 and go to WAIT.
- **WAIT**
  - Decrements the counter each cycle.
  - In the cycle the counter is 0, capture `MemRData` into the result register, then go to DONE.
- **DONE**
  - Pulses `DataDone` or `InstrDone` (granting side only) for one cycle.
  - `DataIn`/`InstrIn` present the captured word; for a write, `DataIn` holds its previous value.
  - Requests are ignored in this cycle, because the requester's previous request is still asserted here.
  - Go to IDLE.
- **Output values outside completion**
  - `DataIn` and `InstrIn` are registered and hold their last value between completions.
  - `MemAddr` and `MemWData` are 0 in IDLE and DONE.
- **Requester rule:** a requester changing its address or deasserting before its Done is a protocol violation. The behaviour is undefined and is not checked.

## Timing
- **Reset values** (Reset high at a rising edge): state=IDLE, `starve_cnt`=0, and every output 0 (`DataIn`, `InstrIn`, `DataDone`, `InstrDone`, `MemAddr`, `MemWData`, `MemRead`, `MemWrite`).
- **Reset mid-operation:** the in-flight transaction is dropped and no Done is issued. Any late `MemRData` is ignored.
- **Read latency:** request first seen in IDLE in cycle T gives ISSUE in T+1 and Done in cycle T+2+`MEM_LATENCY`. With the default latency, that is Done at T+3.
- **Write latency:** Done in cycle T+2.
- **Throughput:** the earliest next grant is the cycle after DONE.
  - Back-to-back reads: one per `MEM_LATENCY`+3 cycles.
  - Back-to-back writes: one per 3 cycles.
- **Exclusivity:** at most one of `MemRead`/`MemWrite` is high in any cycle, and at most one of `DataDone`/`InstrDone` is high in any cycle.

## Test plan
- **Single load.** `MEM_LATENCY`=1, memory[0x10]=0xBEEF. Hold `ReadData`=1, `DataAddr`=0x10 from cycle 0.
  - Expect `MemRead`=1 with `MemAddr`=0x10 in cycle 1.
  - Expect `DataDone`=1 with `DataIn`=0xBEEF in cycle 3 only.
- **Store.** Hold `WriteData`=1, `DataAddr`=0x20, `DataOut`=0x1234.
  - Expect `MemWrite` in cycle 1 with `MemWData`=0x1234, and `DataDone` in cycle 2.
  - A following read of 0x20 returns 0x1234.
- **Contention and starvation.** `STARVE_LIMIT`=4; `InstrReq` and the data request are both held continuously.
  - Expect grant order D,D,D,D,I,D,D,D,D,I.
  - `InstrDone` never pulses in the same cycle as `DataDone`.
- **Latency sweep.** `MEM_LATENCY`=3; fetch from 0x05 holding 0x7A01.
  - Expect `InstrDone`=1 with `InstrIn`=0x7A01 exactly 5 cycles after the first IDLE sample.
  - `MemRead` is high for one cycle only.
- **Read and write both asserted.** Raise `ReadData` and `WriteData` together.
  - Expect only `MemWrite` to pulse, never `MemRead`.
- **Reset mid-read.** Assert `Reset` during WAIT.
  - The next cycle shows all outputs 0 and state IDLE.
  - No Done pulse appears.
  - A new read issued after reset completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port fixed-latency memory between instruction fetch and data access.
// Data has priority; a saturating starvation counter forces a fetch grant after a data run.
module mem_port_arbiter #(
  parameter int unsigned WORD_SIZE    = 16,
  parameter int unsigned ADDR_BITS    = 16,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [ADDR_BITS-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  input  logic                 ReadData,
  input  logic                 WriteData,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataDone,
  input  logic                 InstrReq,
  input  logic [ADDR_BITS-1:0] InstrAddr,
  output logic [WORD_SIZE-1:0] InstrIn,
  output logic                 InstrDone,
  output logic [ADDR_BITS-1:0] MemAddr,
  output logic [WORD_SIZE-1:0] MemWData,
  output logic                 MemRead,
  output logic                 MemWrite,
  input  logic [WORD_SIZE-1:0] MemRData
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);
  localparam logic [3:0] WaitInit  = 4'(MEM_LATENCY - 1);

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
  logic                   is_write_q, is_write_d;
  logic                   is_instr_q, is_instr_d;
  logic [3:0]             starve_cnt_q, starve_cnt_d;
  logic [3:0]             wait_cnt_q, wait_cnt_d;
  logic [WORD_SIZE-1:0]   data_in_q, data_in_d;
  logic [WORD_SIZE-1:0]   instr_in_q, instr_in_d;
  logic                   data_req;
  logic                   grant_instr;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    is_write_d   = is_write_q;
    is_instr_d   = is_instr_q;
    starve_cnt_d = starve_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    data_in_d    = data_in_q;
    instr_in_d   = instr_in_q;
    data_req     = ReadData | WriteData;
    grant_instr  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (data_req || InstrReq) begin
          grant_instr = InstrReq && (!data_req || (starve_cnt_q == StarveMax));
          state_d     = StIssue;
          is_instr_d  = grant_instr;
          if (grant_instr) begin
            addr_d       = InstrAddr;
            wdata_d      = '0;
            is_write_d   = 1'b0;
            starve_cnt_d = '0;
          end else begin
            addr_d     = DataAddr;
            wdata_d    = DataOut;
            // Write wins when both read and write are raised.
            is_write_d = WriteData;
            if (!InstrReq) begin
              starve_cnt_d = '0;
            end else if (starve_cnt_q != StarveMax) begin
              starve_cnt_d = starve_cnt_q + 4'd1;
            end
          end
        end
      end
      StIssue: begin
        if (is_write_q) begin
          state_d = StDone;
        end else begin
          wait_cnt_d = WaitInit;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (wait_cnt_q == '0) begin
          if (is_instr_q) begin
            instr_in_d = MemRData;
          end else begin
            data_in_d = MemRData;
          end
          state_d = StDone;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    MemAddr   = ((state_q == StIssue) || (state_q == StWait)) ? addr_q : '0;
    MemWData  = ((state_q == StIssue) && is_write_q) ? wdata_q : '0;
    MemRead   = (state_q == StIssue) && !is_write_q;
    MemWrite  = (state_q == StIssue) && is_write_q;
    DataDone  = (state_q == StDone) && !is_instr_q;
    InstrDone = (state_q == StDone) && is_instr_q;
    DataIn    = data_in_q;
    InstrIn   = instr_in_q;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      is_write_q   <= 1'b0;
      is_instr_q   <= 1'b0;
      starve_cnt_q <= '0;
      wait_cnt_q   <= '0;
      data_in_q    <= '0;
      instr_in_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      is_write_q   <= is_write_d;
      is_instr_q   <= is_instr_d;
      starve_cnt_q <= starve_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      data_in_q    <= data_in_d;
      instr_in_q   <= instr_in_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a latency-1 instance driven from a vector table and
// hand sequences, plus a latency-3 instance for the fetch latency sweep.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Latency-1 instance signals.
  logic [15:0] d_addr, d_out, i_addr, d_in, i_in, m_addr, m_wdata, m_rdata;
  logic        rd, wr, i_req, d_done, i_done, m_read, m_write;
  // Latency-3 instance signals.
  logic [15:0] d_addr3, d_out3, i_addr3, d_in3, i_in3, m_addr3, m_wdata3, m_rdata3;
  logic        rd3, wr3, i_req3, d_done3, i_done3, m_read3, m_write3;

  mem_port_arbiter #(.WORD_SIZE(16), .ADDR_BITS(16), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut (
    .Clock(clk), .Reset(rst), .DataAddr(d_addr), .DataOut(d_out), .ReadData(rd),
    .WriteData(wr), .DataIn(d_in), .DataDone(d_done), .InstrReq(i_req), .InstrAddr(i_addr),
    .InstrIn(i_in), .InstrDone(i_done), .MemAddr(m_addr), .MemWData(m_wdata),
    .MemRead(m_read), .MemWrite(m_write), .MemRData(m_rdata)
  );

  mem_port_arbiter #(.WORD_SIZE(16), .ADDR_BITS(16), .MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .Clock(clk), .Reset(rst), .DataAddr(d_addr3), .DataOut(d_out3), .ReadData(rd3),
    .WriteData(wr3), .DataIn(d_in3), .DataDone(d_done3), .InstrReq(i_req3),
    .InstrAddr(i_addr3), .InstrIn(i_in3), .InstrDone(i_done3), .MemAddr(m_addr3),
    .MemWData(m_wdata3), .MemRead(m_read3), .MemWrite(m_write3), .MemRData(m_rdata3)
  );

  // Shared memory; only the latency-1 instance writes. Reads outside the valid slot give DEAD.
  logic [15:0] mem [0:65535];
  logic        rv1;
  logic [15:0] rd1;
  logic [2:0]  rv3;
  logic [15:0] rd3_0, rd3_1, rd3_2;

  always @(posedge clk) begin
    if (rst) begin
      mem[16'h0010] <= 16'hBEEF;
      mem[16'h0005] <= 16'h7A01;
      rv1           <= 1'b0;
    end else begin
      if (m_write) mem[m_addr] <= m_wdata;
      rv1 <= m_read;
    end
    rd1 <= mem[m_addr];
  end
  assign m_rdata = rv1 ? rd1 : 16'hDEAD;

  always @(posedge clk) begin
    if (rst) rv3 <= 3'b000;
    else     rv3 <= {rv3[1:0], m_read3};
    rd3_0 <= mem[m_addr3];
    rd3_1 <= rd3_0;
    rd3_2 <= rd3_1;
  end
  assign m_rdata3 = rv3[2] ? rd3_2 : 16'hDEAD;

  typedef struct {
    logic        rd, wr, ireq;
    logic [15:0] daddr, dout, iaddr;
    logic [67:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [67:0] pk(input logic mr, input logic mw, input logic [15:0] ma,
                                     input logic [15:0] mwd, input logic dd,
                                     input logic [15:0] din, input logic id,
                                     input logic [15:0] iin);
    return {mr, mw, ma, mwd, dd, din, id, iin};
  endfunction

  function automatic vec_t mk(input logic r, input logic w, input logic ir,
                              input logic [15:0] da, input logic [15:0] dout,
                              input logic [15:0] ia, input logic [67:0] exp);
    vec_t v;
    v.rd = r; v.wr = w; v.ireq = ir; v.daddr = da; v.dout = dout; v.iaddr = ia; v.exp = exp;
    return v;
  endfunction

  function automatic logic [67:0] outs1();
    return {m_read, m_write, m_addr, m_wdata, d_done, d_in, i_done, i_in};
  endfunction

  function automatic logic [67:0] outs3();
    return {m_read3, m_write3, m_addr3, m_wdata3, d_done3, d_in3, i_done3, i_in3};
  endfunction

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int grants[$];
  int exp_grants[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int excl_bad;
  int rd3_pulses;

  initial begin
    rst = 1'b1;
    {rd, wr, i_req, rd3, wr3, i_req3} = '0;
    {d_addr, d_out, i_addr, d_addr3, d_out3, i_addr3} = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_outs_lat1", outs1(), '0);
    check("reset_outs_lat3", outs3(), '0);

    // Single load, store, read-back, read+write together, single fetch.
    vecs.push_back(mk(1, 0, 0, 16'h10, 0, 0, pk(0, 0, 0, 0, 0, 16'h0000, 0, 0)));
    vecs.push_back(mk(1, 0, 0, 16'h10, 0, 0, pk(1, 0, 16'h10, 0, 0, 16'h0000, 0, 0)));
    vecs.push_back(mk(1, 0, 0, 16'h10, 0, 0, pk(0, 0, 16'h10, 0, 0, 16'h0000, 0, 0)));
    vecs.push_back(mk(1, 0, 0, 16'h10, 0, 0, pk(0, 0, 0, 0, 1, 16'hBEEF, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 16'hBEEF, 0, 0)));
    vecs.push_back(mk(0, 1, 0, 16'h20, 16'h1234, 0, pk(0, 0, 0, 0, 0, 16'hBEEF, 0, 0)));
    vecs.push_back(mk(0, 1, 0, 16'h20, 16'h1234, 0,
                      pk(0, 1, 16'h20, 16'h1234, 0, 16'hBEEF, 0, 0)));
    vecs.push_back(mk(0, 1, 0, 16'h20, 16'h1234, 0, pk(0, 0, 0, 0, 1, 16'hBEEF, 0, 0)));
    vecs.push_back(mk(1, 0, 0, 16'h20, 0, 0, pk(0, 0, 0, 0, 0, 16'hBEEF, 0, 0)));
    vecs.push_back(mk(1, 0, 0, 16'h20, 0, 0, pk(1, 0, 16'h20, 0, 0, 16'hBEEF, 0, 0)));
    vecs.push_back(mk(1, 0, 0, 16'h20, 0, 0, pk(0, 0, 16'h20, 0, 0, 16'hBEEF, 0, 0)));
    vecs.push_back(mk(1, 0, 0, 16'h20, 0, 0, pk(0, 0, 0, 0, 1, 16'h1234, 0, 0)));
    vecs.push_back(mk(1, 1, 0, 16'h30, 16'h5555, 0, pk(0, 0, 0, 0, 0, 16'h1234, 0, 0)));
    vecs.push_back(mk(1, 1, 0, 16'h30, 16'h5555, 0,
                      pk(0, 1, 16'h30, 16'h5555, 0, 16'h1234, 0, 0)));
    vecs.push_back(mk(1, 1, 0, 16'h30, 16'h5555, 0, pk(0, 0, 0, 0, 1, 16'h1234, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 16'h1234, 0, 0)));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h05, pk(0, 0, 0, 0, 0, 16'h1234, 0, 0)));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h05, pk(1, 0, 16'h05, 0, 0, 16'h1234, 0, 0)));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h05, pk(0, 0, 16'h05, 0, 0, 16'h1234, 0, 0)));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h05, pk(0, 0, 0, 0, 0, 16'h1234, 1, 16'h7A01)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 16'h1234, 0, 16'h7A01)));

    foreach (vecs[i]) begin
      rd = vecs[i].rd; wr = vecs[i].wr; i_req = vecs[i].ireq;
      d_addr = vecs[i].daddr; d_out = vecs[i].dout; i_addr = vecs[i].iaddr;
      check($sformatf("vec%0d", i), outs1(), vecs[i].exp);
      tick();
    end

    // Contention: both sides held; data runs of four, then one fetch.
    rd = 1'b1; d_addr = 16'h10; i_req = 1'b1; i_addr = 16'h05;
    excl_bad = 0;
    for (int cyc = 0; cyc < 100 && grants.size() < 10; cyc++) begin
      if (m_read && m_write) excl_bad++;
      if (d_done && i_done) excl_bad++;
      if (d_done) begin
        grants.push_back(0);
        check("contention_data_word", {52'd0, d_in}, {52'd0, 16'hBEEF});
      end else if (i_done) begin
        grants.push_back(1);
        check("contention_instr_word", {52'd0, i_in}, {52'd0, 16'h7A01});
      end
      tick();
    end
    rd = 1'b0; i_req = 1'b0;
    check("contention_grant_count", 68'(grants.size()), 68'd10);
    for (int g = 0; g < 10 && g < grants.size(); g++)
      check($sformatf("grant%0d", g), 68'(grants[g]), 68'(exp_grants[g]));
    check("exclusivity", 68'(excl_bad), 68'd0);
    tick();

    // Latency sweep on the latency-3 instance: fetch done 5 cycles after first sample.
    i_req3 = 1'b1; i_addr3 = 16'h05;
    rd3_pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (m_read3) rd3_pulses++;
      check($sformatf("lat3_done_c%0d", k), {67'd0, i_done3}, {67'd0, (k == 5)});
      if (k == 5) begin
        check("lat3_word", outs3(), pk(0, 0, 0, 0, 0, 0, 1, 16'h7A01));
      end
      tick();
      if (k == 5) i_req3 = 1'b0;
    end
    check("lat3_read_pulses", 68'(rd3_pulses), 68'd1);

    // Reset during WAIT drops the read; a fresh read then completes normally.
    rd = 1'b1; d_addr = 16'h10;
    tick();
    tick();
    check("pre_reset_wait_no_done", {67'd0, d_done}, 68'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_mid_read_outs", outs1(), '0);
    for (int k = 3; k < 9; k++) begin
      check($sformatf("post_reset_done_c%0d", k), {67'd0, d_done}, {67'd0, (k == 6)});
      if (k == 6) check("post_reset_word", {52'd0, d_in}, {52'd0, 16'hBEEF});
      tick();
      if (k == 6) rd = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
